// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the copy engine: read/write ports of a 1-cycle registered-read dual-port RAM.
interface mem_copy_engine_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic              rd;
  logic [ADDR_W-1:0] read_adr;
  logic              wr;
  logic [ADDR_W-1:0] write_adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output rd, read_adr, wr, write_adr, wdata, input rdata);
  modport slave  (input rd, read_adr, wr, write_adr, wdata, output rdata);
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: streams len words src->dst one per cycle through a registered-read RAM,
// accumulating an XOR checksum of every word written.
module mem_copy_engine #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   src_adr,
  input  logic [ADDR_W-1:0]   dst_adr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_done,
  output logic [DATA_W-1:0]   checksum,
  mem_copy_engine_if.master   mem
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADR_ONE = ADR_ONE_VAL();
  localparam logic [ADDR_W:0]   CNT_ONE = CNT_ONE_VAL();

  function automatic logic [ADDR_W-1:0] ADR_ONE_VAL();
    logic [ADDR_W-1:0] v;
    v = '0;
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [ADDR_W:0] CNT_ONE_VAL();
    logic [ADDR_W:0] v;
    v = '0;
    v[0] = 1'b1;
    return v;
  endfunction

  state_t            state;
  logic              rd_q;
  logic [ADDR_W-1:0] rd_adr;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   len_q;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_fire;

  // Abort must suppress the read in the very cycle it is raised, so the read strobe
  // is the only output that is not purely registered. rd_q is only ever set in RUN.
  assign rd_fire = rd_q & ~abort;

  assign mem.rd        = rd_fire;
  assign mem.read_adr  = rd_adr;
  assign mem.wr        = wr_q;
  assign mem.write_adr = wr_adr;
  assign mem.wdata     = wr_q ? mem.rdata : '0;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_q       <= 1'b0;
      rd_adr     <= '0;
      rd_cnt     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      wr_adr     <= '0;
      wr_ptr     <= '0;
      words_done <= '0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;

      // Write side trails the read side by exactly one cycle.
      wr_q <= rd_fire;
      if (rd_fire) begin
        wr_adr <= wr_ptr;
        wr_ptr <= wr_ptr + ADR_ONE;
      end
      if (wr_q) begin
        words_done <= words_done + CNT_ONE;
        checksum   <= checksum ^ mem.rdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            rd_adr     <= src_adr;
            wr_ptr     <= dst_adr;
            len_q      <= len;
            words_done <= '0;
            checksum   <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              rd_q   <= 1'b1;
              rd_cnt <= CNT_ONE;
            end
          end
        end
        RUN: begin
          if (abort || rd_cnt == len_q) begin
            rd_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_adr <= rd_adr + ADR_ONE;
            rd_cnt <= rd_cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: RAM model on the bus, sequential-copy reference model.
module tb_mem_copy_engine;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_adr = '0;
  logic [AW-1:0] dst_adr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [AW:0]   words_done;
  logic [DW-1:0] checksum;

  mem_copy_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .src_adr    (src_adr),
    .dst_adr    (dst_adr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .checksum   (checksum),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write-to-read forwarding on equal addresses, bulk backdoor load.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          bd_load = 1'b0;

  always @(posedge clk) begin
    if (bd_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else begin
      if (bus.wr) mem[bus.write_adr] <= bus.wdata;
      if (bus.rd)
        bus.rdata <= (bus.wr && bus.write_adr == bus.read_adr) ? bus.wdata : mem[bus.read_adr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(posedge clk); #1 bd_load = 1'b1;
    @(posedge clk); #1 bd_load = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) errs++;
    check({tag, " mem"}, errs, 0);
  endtask

  // Runs one job with the reference model applied to ref_mem; abort_cyc/restart_cyc = 0 disables.
  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] n,
                         input int abort_cyc, input int restart_cyc, input string tag);
    int words, exp_done, cyc, done_cyc;
    int rd_n, wr_n, rd_first, rd_last, wr_first, wr_last, adr_err, busy_err;
    logic [DW-1:0] exp_sum, v;
    logic [AW-1:0] a;
    logic exp_busy;

    load_mem();

    // Reference: sequential ascending word-by-word copy.
    words = (abort_cyc > 0 && abort_cyc <= int'(n)) ? abort_cyc - 1 : int'(n);
    exp_sum = '0;
    for (int k = 0; k < words; k++) begin
      a = src + AW'(k);
      v = ref_mem[a];
      a = dst + AW'(k);
      ref_mem[a] = v;
      exp_sum ^= v;
    end
    if (n == 0) exp_done = 1;
    else if (abort_cyc > 0 && abort_cyc <= int'(n)) exp_done = abort_cyc + 2;
    else exp_done = int'(n) + 2;

    @(posedge clk); #1;
    src_adr = src; dst_adr = dst; len = n; start = 1'b1;
    @(posedge clk);
    cyc = 0; done_cyc = 0;
    rd_n = 0; wr_n = 0; rd_first = 0; rd_last = 0; wr_first = 0; wr_last = 0;
    adr_err = 0; busy_err = 0;
    while (done_cyc == 0 && cyc < 3000) begin
      #1;
      cyc++;
      start = (cyc == restart_cyc);
      abort = (cyc == abort_cyc);
      if (cyc == restart_cyc) begin
        src_adr = ~src; dst_adr = ~dst; len = 11'd2;
      end
      @(negedge clk);
      if (bus.rd) begin
        rd_n++;
        if (rd_first == 0) rd_first = cyc;
        rd_last = cyc;
        if (bus.read_adr != AW'(int'(src) + cyc - 1)) adr_err++;
      end
      if (bus.wr) begin
        wr_n++;
        if (wr_first == 0) wr_first = cyc;
        wr_last = cyc;
        if (bus.write_adr != AW'(int'(dst) + cyc - 2)) adr_err++;
      end
      exp_busy = (n != 0) && (cyc < exp_done);
      if (busy !== exp_busy) busy_err++;
      if (done) done_cyc = cyc;
      else @(posedge clk);
    end
    start = 1'b0;
    abort = 1'b0;

    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " reads"}, rd_n, words);
    check({tag, " writes"}, wr_n, words);
    if (words > 0) begin
      check({tag, " first_read_cycle"}, rd_first, 1);
      check({tag, " last_read_cycle"}, rd_last, words);
      check({tag, " first_write_cycle"}, wr_first, 2);
      check({tag, " last_write_cycle"}, wr_last, words + 1);
    end
    check({tag, " addr_errors"}, adr_err, 0);
    check({tag, " busy_errors"}, busy_err, 0);
    check({tag, " words_done"}, words_done, words);
    check({tag, " checksum"}, checksum, exp_sum);

    // done lasts one cycle; results hold and nothing restarts afterwards.
    @(negedge clk);
    check({tag, " done_pulse"}, done, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " hold_words"}, words_done, words);
    check({tag, " hold_checksum"}, checksum, exp_sum);
    check_mem(tag);
  endtask

  task automatic reset_mid_job();
    int wr_after;
    logic [AW-1:0] src, dst;
    src = AW'(400); dst = AW'(600);
    load_mem();
    ref_mem[dst] = ref_mem[src];
    @(posedge clk); #1;
    src_adr = src; dst_adr = dst; len = 11'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid mem_wr", bus.wr, 1'b0);
    check("rst_mid mem_rd", bus.rd, 1'b0);
    check("rst_mid words_done", words_done, 0);
    wr_after = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.wr) wr_after++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.wr) wr_after++;
    end
    check("rst_mid writes_after", wr_after, 0);
    check_mem("rst_mid");
  endtask

  initial begin
    logic [AW-1:0] rs, rdst;
    logic [AW:0]   rn;
    int            ab;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {$urandom, $urandom};

    #2;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset mem_rd", bus.rd, 1'b0);
    check("reset mem_wr", bus.wr, 1'b0);
    check("reset words_done", words_done, 0);
    check("reset checksum", checksum, 0);
    check("reset addrs", {bus.read_adr, bus.write_adr}, 0);
    check("reset wdata", bus.wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    ref_mem[0] = 64'h11; ref_mem[1] = 64'h22; ref_mem[2] = 64'h33; ref_mem[3] = 64'h44;
    run_job(10'd0, 10'd100, 11'd4, 0, 0, "basic");
    check("basic checksum_const", checksum, 64'h44);

    run_job(10'd1022, 10'd5, 11'd4, 0, 0, "wrap");

    ref_mem[10] = 64'hAA; ref_mem[11] = '0; ref_mem[12] = '0; ref_mem[13] = '0;
    run_job(10'd10, 10'd11, 11'd3, 0, 0, "overlap");
    check("overlap mem13", mem[13], 64'hAA);

    run_job(10'd7, 10'd50, 11'd0, 0, 0, "len0");
    run_job(10'd20, 10'd200, 11'd8, 3, 0, "abort");
    run_job(10'd30, 10'd300, 11'd6, 0, 2, "restart");
    run_job(10'd40, 10'd700, 11'd5, 1, 0, "abort_first");

    reset_mid_job();

    for (int t = 0; t < 10; t++) begin
      rs   = AW'($urandom);
      rdst = AW'($urandom);
      rn   = (AW + 1)'($urandom_range(1, 40));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 0;
      run_job(rs, rdst, rn, ab, 0, $sformatf("rand%0d", t));
    end

    run_job(10'd900, 10'd901, 11'd1024, 0, 0, "full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
